// File: rtl/seq_gen_ctrl.sv
// ---------------------------------------------------------------------------
// seq_gen_ctrl
//
// Sequencing controller for the repeated-value sequence 1, 2, 2, 3, 3, 3, ...
// A start command latches an upper bound N. The block then streams every
// value k (1..N) k times over a valid/ready interface, pulses done and
// returns to idle. A downstream consumer may stall the stream at any time.
//
// Optional feature macro: SEQ_GEN_CTRL_MIRROR_EN
//   When defined, the stream descends again after reaching N
//   (e.g. N = 3 gives 1,2,2,3,3,3,2,2,1), so N*N beats are sent in total.
//   When undefined, the DOWN state and its logic are not built.
//
// Parameters:
//   WIDTH      width of the bound, the value and the repeat counter
//              (default `DATA_WIDTH, falling back to 8 if it is not defined)
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   start      in   1      start command, only looked at while idle
//   abort      in   1      ends the current sequence, only looked at while busy
//   max_val    in   WIDTH  bound N, latched when a start is accepted
//   out_data   out  WIDTH  current sequence value (registered)
//   out_valid  out  1      out_data is valid (registered)
//   out_ready  in   1      consumer takes the beat on out_valid && out_ready
//   busy       out  1      a sequence is in progress
//   done       out  1      one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module seq_gen_ctrl #(
    parameter int WIDTH = `DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_GEN_CTRL_MIRROR_EN
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
`else
    typedef enum logic [1:0] {IDLE, UP} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bound_q, bound_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] rep_left_q, rep_left_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             handshake;

    assign handshake = out_valid_q && out_ready;

    // Next-state logic. Everything holds unless a start is accepted, a beat
    // is handed over or an abort arrives, which keeps out_data/out_valid
    // stable while the consumer stalls. Abort is checked before the
    // handshake so that an abort on the final beat suppresses done.
    always_comb begin
        state_d     = state_q;
        bound_d     = bound_q;
        value_d     = value_q;
        rep_left_d  = rep_left_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (max_val != '0) begin
                        bound_d     = max_val;
                        value_d     = WIDTH'(1);
                        rep_left_d  = WIDTH'(1);
                        state_d     = UP;
                        busy_d      = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        // Empty sequence: no beats, just the completion pulse.
                        done_d = 1'b1;
                    end
                end
            end

            UP: begin
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (handshake) begin
                    if (rep_left_q > WIDTH'(1)) begin
                        rep_left_d = rep_left_q - WIDTH'(1);
                    end else if (value_q < bound_q) begin
                        // value < bound, so value + 1 cannot wrap.
                        value_d    = value_q + WIDTH'(1);
                        rep_left_d = value_q + WIDTH'(1);
`ifdef SEQ_GEN_CTRL_MIRROR_EN
                    end else if (bound_q > WIDTH'(1)) begin
                        value_d    = bound_q - WIDTH'(1);
                        rep_left_d = bound_q - WIDTH'(1);
                        state_d    = DOWN;
`endif
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end

`ifdef SEQ_GEN_CTRL_MIRROR_EN
            DOWN: begin
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (handshake) begin
                    if (rep_left_q > WIDTH'(1)) begin
                        rep_left_d = rep_left_q - WIDTH'(1);
                    end else if (value_q > WIDTH'(1)) begin
                        value_d    = value_q - WIDTH'(1);
                        rep_left_d = value_q - WIDTH'(1);
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset mid-run
    // discards the partial sequence without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bound_q     <= '0;
            value_q     <= '0;
            rep_left_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bound_q     <= bound_d;
            value_q     <= value_d;
            rep_left_q  <= rep_left_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = value_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_gen_ctrl
//
// Self-checking bench for seq_gen_ctrl. Expected beats are pushed to a
// scoreboard queue when a start is issued and popped whenever the DUT hands
// a beat over. Outputs are sampled 1 time unit after each rising edge.
// Honours SEQ_GEN_CTRL_MIRROR_EN in its reference model.
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_seq_gen_ctrl;

    localparam int W = `DATA_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] max_val;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];

    seq_gen_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .max_val   (max_val),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // One comparison: counted, and reported with tag/observed/expected on failure.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: value k repeated k times up to n, optionally mirrored down.
    task automatic push_expected(input int n);
        for (int k = 1; k <= n; k++)
            for (int r = 0; r < k; r++)
                exp_q.push_back(W'(k));
`ifdef SEQ_GEN_CTRL_MIRROR_EN
        for (int k = n - 1; k >= 1; k--)
            for (int r = 0; r < k; r++)
                exp_q.push_back(W'(k));
`endif
    endtask

    // Issue a one-cycle start with bound n and check the cycle after it.
    task automatic apply_stimulus(input int n);
        exp_q.delete();
        push_expected(n);
        start   = 1'b1;
        max_val = W'(n);
        tick();
        start   = 1'b0;
        if (n != 0) begin
            check_output("first_valid", out_valid, 1);
            check_output("first_data", out_data, 1);
            check_output("first_busy", busy, 1);
            check_output("first_no_done", done, 0);
        end else begin
            check_output("zero_done", done, 1);
            check_output("zero_busy", busy, 0);
            check_output("zero_valid", out_valid, 0);
            tick();
            check_output("zero_done_low", done, 0);
            check_output("zero_busy_low", busy, 0);
            check_output("zero_valid_low", out_valid, 0);
        end
    endtask

    // Consume beats. mode 0: ready always high; mode 1: ready 1,0,0 repeating.
    // stop_after > 0 returns after that many beats without expecting done.
    // poke_start raises start (bound 7) on the first cycle; it must be ignored.
    task automatic drain(input int mode, input int stop_after, input bit poke_start);
        int           n_hs     = 0;
        bit           finished = 1'b0;
        bit           stalled;
        logic [W-1:0] held;
        logic [W-1:0] e;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (poke_start && cyc == 0) begin
                start   = 1'b1;
                max_val = W'(7);
            end
            check_output("valid_while_busy", out_valid, 1);
            check_output("no_early_done", done, 0);
            stalled = !out_ready;
            held    = out_data;
            if (out_ready) begin
                check_output("queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_output("beat_data", out_data, e);
                end
                n_hs++;
            end
            tick();
            start = 1'b0;
            if (stalled) begin
                check_output("stall_valid", out_valid, 1);
                check_output("stall_data", out_data, held);
            end else if (stop_after > 0 && n_hs == stop_after) begin
                finished = 1'b1;
            end else if (exp_q.size() == 0) begin
                check_output("done_pulse", done, 1);
                check_output("done_valid_low", out_valid, 0);
                check_output("done_busy_low", busy, 0);
                tick();
                check_output("done_one_cycle", done, 0);
                check_output("idle_valid_low", out_valid, 0);
                finished = 1'b1;
            end
        end
        check_output("finished_in_budget", finished, 1);
        out_ready = 1'b1;
    endtask

    initial begin
        logic [W-1:0] e;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        max_val   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check_output("rst_out_data", out_data, 0);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);

        // N = 3, consumer always ready.
        $display("[TB] N=3 full rate");
        apply_stimulus(3);
        drain(0, 0, 1'b0);

        // N = 3 with backpressure.
        $display("[TB] N=3 with stalls");
        apply_stimulus(3);
        drain(1, 0, 1'b0);

        // Empty sequence.
        $display("[TB] N=0");
        apply_stimulus(0);

        // Abort together with the 4th handshake (value 3) of N = 4.
        $display("[TB] abort on 4th beat");
        apply_stimulus(4);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            check_output("abort_pre_data", out_data, e);
            tick();
        end
        e = exp_q.pop_front();
        check_output("abort_beat_data", out_data, e);
        check_output("abort_beat_valid", out_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("abort_valid", out_valid, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_no_done", done, 0);
        tick();
        check_output("abort_no_done_later", done, 0);
        check_output("abort_still_idle", out_valid, 0);

        // Restart with N = 2 after the abort.
        $display("[TB] N=2 after abort");
        apply_stimulus(2);
        drain(0, 0, 1'b0);

        // Start pulsed mid-sequence is ignored.
        $display("[TB] start while busy");
        apply_stimulus(3);
        drain(0, 0, 1'b1);

        // Reset mid-sequence discards the run.
        $display("[TB] reset mid-sequence");
        apply_stimulus(3);
        drain(0, 2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midrst_out_data", out_data, 0);
        check_output("midrst_out_valid", out_valid, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_done", done, 0);
        tick();
        check_output("midrst_no_done", done, 0);
        check_output("midrst_idle", out_valid, 0);

        // Bound of 1: single beat in both builds.
        $display("[TB] N=1");
        apply_stimulus(1);
        drain(0, 0, 1'b0);

        // Larger bound with stalls to exercise longer runs.
        $display("[TB] N=6 with stalls");
        apply_stimulus(6);
        drain(1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
